interrupt_status_collector: RTL and testbench



---
 rtl/riffa_intr_pkg.sv | 33 +++
 rtl/interrupt_status_collector_if.sv | 52 +++++
 rtl/interrupt_status_collector.sv | 139 +++++++++++++
 tb/tb_interrupt_status_collector.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riffa_intr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riffa_intr_pkg
//  Description : Shared types and helpers for the interrupt path: the
//                status-collector state encoding, the host status register
//                width, and the mapping from channel number to event bit.
//  Revision    : 1.0 - initial release
// ============================================================================
package riffa_intr_pkg;

    // Width of the host-visible status register.
    localparam int C_STATUS_W = 32;

    // Collector FSM encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        REQ  = 2'd2,
        WAIT = 2'd3
    } intr_coll_state_t;

    // Event vector layout: channel i RX-done lives at bit 2i and TX-done at
    // bit 2i+1.
    function automatic int unsigned rx_bit(input int unsigned ch);
        return 2 * ch;
    endfunction

    function automatic int unsigned tx_bit(input int unsigned ch);
        return (2 * ch) + 1;
    endfunction

endpackage : riffa_intr_pkg
`default_nettype wire

// File: rtl/interrupt_status_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_status_collector_if
//  Description : Bundle between the status collector and its neighbours
//                (channel engines, PIO register decode, interrupt_controller).
//                  CHNL_EVENT                 : per-channel done pulses
//                  CONFIG_INTERRUPT_MSIENABLE : 1 = MSI, 0 = legacy
//                  INTR / INTR_DONE           : request pulse / completion
//                  INTR_LEGACY_CLR            : legacy-clear pulse
//                  STATUS_RD / STATUS_DATA    : host read strobe / snapshot
//                  BUSY                       : collector not idle
//                'master' is the surrounding system, 'slave' is the collector.
//  Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_status_collector_if #(
    parameter int C_NUM_CHNL = 12
) ();
    import riffa_intr_pkg::*;

    logic [2*C_NUM_CHNL-1:0] CHNL_EVENT;
    logic                    CONFIG_INTERRUPT_MSIENABLE;
    logic                    INTR;
    logic                    INTR_DONE;
    logic                    INTR_LEGACY_CLR;
    logic                    STATUS_RD;
    logic [C_STATUS_W-1:0]   STATUS_DATA;
    logic                    BUSY;

    modport master (
        output CHNL_EVENT,
        output CONFIG_INTERRUPT_MSIENABLE,
        output INTR_DONE,
        output STATUS_RD,
        input  INTR,
        input  INTR_LEGACY_CLR,
        input  STATUS_DATA,
        input  BUSY
    );

    modport slave (
        input  CHNL_EVENT,
        input  CONFIG_INTERRUPT_MSIENABLE,
        input  INTR_DONE,
        input  STATUS_RD,
        output INTR,
        output INTR_LEGACY_CLR,
        output STATUS_DATA,
        output BUSY
    );

endinterface : interrupt_status_collector_if
`default_nettype wire

// File: rtl/interrupt_status_collector.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_status_collector
//  Description : Collects per-channel completion events into a sticky pending
//                vector, raises a single interrupt request per batch (with an
//                optional coalescing window), and presents the batch to the
//                host as a read-to-clear status register. In legacy mode the
//                first status read of an interrupt produces the legacy-clear
//                pulse for interrupt_controller.
//  Ports       : CLK  - system clock
//                RST  - synchronous active-high reset
//                bus  - interrupt_status_collector_if.slave (events, request,
//                       completion, legacy clear, status read/data, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_status_collector
    import riffa_intr_pkg::*;
#(
    parameter int C_NUM_CHNL = 12,
    parameter int C_HOLDOFF  = 0
) (
    input  wire logic                   CLK,
    input  wire logic                   RST,
    interrupt_status_collector_if.slave bus
);

    localparam int         c_evt_w       = 2 * C_NUM_CHNL;
    localparam logic [7:0] c_holdoff_cnt = 8'(C_HOLDOFF);

    intr_coll_state_t   r_state;
    logic [c_evt_w-1:0] r_pending;
    logic [c_evt_w-1:0] r_snapshot;
    logic [7:0]         r_count;
    logic               r_done_seen;
    logic               r_read_seen;
    logic               r_intr;
    logic               r_legacy_clr;
    logic               r_busy;

    logic [c_evt_w-1:0] w_event;
    logic               w_read_accept;
    logic               w_wait_exit;

    assign w_event = bus.CHNL_EVENT;

    // Only the first read of an interrupt is acted on; later reads see the
    // already-cleared snapshot.
    assign w_read_accept = (r_state == WAIT) && bus.STATUS_RD && !r_read_seen;

    // A flag counts as set when its strobe is high in the current cycle, so
    // completion and read arriving together leave WAIT immediately.
    assign w_wait_exit = (r_done_seen || bus.INTR_DONE) &&
                         (r_read_seen || bus.STATUS_RD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_pending    <= '0;
            r_snapshot   <= '0;
            r_count      <= '0;
            r_done_seen  <= 1'b0;
            r_read_seen  <= 1'b0;
            r_intr       <= 1'b0;
            r_legacy_clr <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_intr       <= 1'b0;
            r_legacy_clr <= 1'b0;
            r_pending    <= r_pending | w_event;

            case (r_state)
                IDLE: begin
                    if (r_pending != '0) begin
                        r_busy <= 1'b1;
                        if (c_holdoff_cnt == 8'd0) begin
                            r_state <= REQ;
                            r_intr  <= 1'b1;
                        end else begin
                            r_state <= HOLD;
                            r_count <= c_holdoff_cnt;
                        end
                    end
                end

                HOLD: begin
                    r_count <= r_count - 8'd1;
                    if (r_count <= 8'd1) begin
                        r_state <= REQ;
                        r_intr  <= 1'b1;
                    end
                end

                REQ: begin
                    // Events landing in the request cycle start the next batch
                    // instead of being folded into this snapshot.
                    r_snapshot  <= r_pending;
                    r_pending   <= w_event;
                    r_done_seen <= 1'b0;
                    r_read_seen <= 1'b0;
                    r_state     <= WAIT;
                end

                WAIT: begin
                    if (bus.INTR_DONE) begin
                        r_done_seen <= 1'b1;
                    end
                    if (w_read_accept) begin
                        r_read_seen  <= 1'b1;
                        r_snapshot   <= '0;
                        r_legacy_clr <= !bus.CONFIG_INTERRUPT_MSIENABLE;
                    end
                    if (w_wait_exit) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.INTR            = r_intr;
    assign bus.INTR_LEGACY_CLR = r_legacy_clr;
    assign bus.BUSY            = r_busy;

    generate
        if (c_evt_w < C_STATUS_W) begin : g_pad_status
            assign bus.STATUS_DATA = {{(C_STATUS_W - c_evt_w){1'b0}}, r_snapshot};
        end else begin : g_full_status
            assign bus.STATUS_DATA = r_snapshot;
        end
    endgenerate

endmodule : interrupt_status_collector
`default_nettype wire

// File: tb/tb_interrupt_status_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_status_collector
//  Description : Self-checking bench for interrupt_status_collector. Two
//                instances: dut0 (12 channels, no holdoff) and dut4
//                (8 channels, holdoff 4). Expected request cycles and
//                snapshots are queued when events are driven and compared
//                when the request or status read happens.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_status_collector;
    import riffa_intr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          q_cyc[$];
    logic [31:0] q_snap[$];

    always #5 clk = ~clk;

    interrupt_status_collector_if #(.C_NUM_CHNL(12)) if0 ();
    interrupt_status_collector_if #(.C_NUM_CHNL(8))  if4 ();

    interrupt_status_collector #(.C_NUM_CHNL(12), .C_HOLDOFF(0)) dut0 (
        .CLK (clk),
        .RST (rst),
        .bus (if0)
    );

    interrupt_status_collector #(.C_NUM_CHNL(8), .C_HOLDOFF(4)) dut4 (
        .CLK (clk),
        .RST (rst),
        .bus (if4)
    );

    // Advance one cycle; inputs are driven and outputs sampled 1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_intr(input bit sel, output int found);
        found = -1;
        for (int k = 0; k < 40; k++) begin
            if ((sel ? if4.INTR : if0.INTR) === 1'b1) begin
                found = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        if0.CHNL_EVENT = '0; if0.CONFIG_INTERRUPT_MSIENABLE = 1'b1;
        if0.INTR_DONE = 1'b0; if0.STATUS_RD = 1'b0;
        if4.CHNL_EVENT = '0; if4.CONFIG_INTERRUPT_MSIENABLE = 1'b1;
        if4.INTR_DONE = 1'b0; if4.STATUS_RD = 1'b0;
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if (if0.INTR !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b expected 0", if0.INTR); end
        checks++; if (if0.INTR_LEGACY_CLR !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b expected 0", if0.INTR_LEGACY_CLR); end
        checks++; if (if0.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if0.BUSY); end
        checks++; if (if0.STATUS_DATA !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", if0.STATUS_DATA); end
        checks++; if (if4.INTR !== 1'b0 || if4.BUSY !== 1'b0) begin errors++; $display("FAIL reset_dut4: intr %b busy %b expected 0 0", if4.INTR, if4.BUSY); end
        checks++; if (if4.STATUS_DATA !== 32'h0) begin errors++; $display("FAIL reset_dut4_data: got %h expected 0", if4.STATUS_DATA); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (if0.BUSY !== 1'b0 || if0.INTR !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b intr %b expected 0 0", if0.BUSY, if0.INTR); end
    endtask

    task automatic test_msi_basic();
        int t, found, exp_c;
        logic [31:0] exp_s;
        if0.CONFIG_INTERRUPT_MSIENABLE = 1'b1;
        t = cyc;
        if0.CHNL_EVENT = 24'(1) << tx_bit(1);
        q_cyc.push_back(t + 2); q_snap.push_back(32'h0000_0008);
        tick(); if0.CHNL_EVENT = '0;
        wait_intr(1'b0, found);
        exp_c = q_cyc.pop_front();
        checks++; if (found !== exp_c) begin errors++; $display("FAIL msi_latency: INTR at cycle %0d expected %0d", found, exp_c); end
        checks++; if (if0.BUSY !== 1'b1) begin errors++; $display("FAIL msi_busy: got %b expected 1", if0.BUSY); end
        tick();
        checks++; if (if0.INTR !== 1'b0) begin errors++; $display("FAIL msi_intr_pulse: got %b expected 0", if0.INTR); end
        if0.INTR_DONE = 1'b1;
        tick(); if0.INTR_DONE = 1'b0; if0.STATUS_RD = 1'b1;
        exp_s = q_snap.pop_front();
        checks++; if (if0.STATUS_DATA !== exp_s) begin errors++; $display("FAIL msi_snapshot: got %h expected %h", if0.STATUS_DATA, exp_s); end
        tick(); if0.STATUS_RD = 1'b0;
        checks++; if (if0.STATUS_DATA !== 32'h0) begin errors++; $display("FAIL msi_cleared: got %h expected 0", if0.STATUS_DATA); end
        checks++; if (if0.INTR_LEGACY_CLR !== 1'b0) begin errors++; $display("FAIL msi_no_clr: got %b expected 0", if0.INTR_LEGACY_CLR); end
        checks++; if (if0.BUSY !== 1'b0) begin errors++; $display("FAIL msi_exit: busy %b expected 0", if0.BUSY); end
    endtask

    task automatic test_legacy();
        int t, found, exp_c;
        logic [31:0] exp_s;
        if0.CONFIG_INTERRUPT_MSIENABLE = 1'b0;
        t = cyc;
        if0.CHNL_EVENT = 24'(1) << rx_bit(0);
        q_cyc.push_back(t + 2); q_snap.push_back(32'h0000_0001);
        tick(); if0.CHNL_EVENT = '0;
        wait_intr(1'b0, found);
        exp_c = q_cyc.pop_front();
        checks++; if (found !== exp_c) begin errors++; $display("FAIL legacy_latency: INTR at cycle %0d expected %0d", found, exp_c); end
        tick(); if0.STATUS_RD = 1'b1;
        exp_s = q_snap.pop_front();
        checks++; if (if0.STATUS_DATA !== exp_s) begin errors++; $display("FAIL legacy_snapshot: got %h expected %h", if0.STATUS_DATA, exp_s); end
        checks++; if (if0.INTR_LEGACY_CLR !== 1'b0) begin errors++; $display("FAIL legacy_clr_early: got %b expected 0", if0.INTR_LEGACY_CLR); end
        tick();  // duplicate read held high in WAIT
        checks++; if (if0.INTR_LEGACY_CLR !== 1'b1) begin errors++; $display("FAIL legacy_clr: got %b expected 1", if0.INTR_LEGACY_CLR); end
        checks++; if (if0.STATUS_DATA !== 32'h0) begin errors++; $display("FAIL legacy_dup_data: got %h expected 0", if0.STATUS_DATA); end
        tick(); if0.STATUS_RD = 1'b0; if0.INTR_DONE = 1'b1;
        checks++; if (if0.INTR_LEGACY_CLR !== 1'b0) begin errors++; $display("FAIL legacy_dup_clr: got %b expected 0", if0.INTR_LEGACY_CLR); end
        checks++; if (if0.BUSY !== 1'b1) begin errors++; $display("FAIL legacy_busy_hold: got %b expected 1", if0.BUSY); end
        tick(); if0.INTR_DONE = 1'b0;
        checks++; if (if0.BUSY !== 1'b0) begin errors++; $display("FAIL legacy_busy_fall: got %b expected 0", if0.BUSY); end
        if0.CONFIG_INTERRUPT_MSIENABLE = 1'b1;
        tick();
    endtask

    task automatic test_coalesce();
        int t, found, npulse, exp_c;
        logic [31:0] exp_s;
        logic [15:0] ev;
        if4.CONFIG_INTERRUPT_MSIENABLE = 1'b1;
        t = cyc; npulse = 0; found = -1;
        q_cyc.push_back(t + 6); q_snap.push_back(32'h0000_0222);
        for (int k = 0; k < 16; k++) begin
            case (k)
                0:       ev = 16'h0002;
                1:       ev = 16'h0020;
                3:       ev = 16'h0200;
                default: ev = 16'h0000;
            endcase
            if4.CHNL_EVENT = ev;
            if (if4.INTR === 1'b1) begin
                npulse++;
                found = cyc;
            end
            tick();
        end
        if4.CHNL_EVENT = '0;
        exp_c = q_cyc.pop_front();
        checks++; if (npulse !== 1) begin errors++; $display("FAIL coalesce_count: got %0d pulses expected 1", npulse); end
        checks++; if (found !== exp_c) begin errors++; $display("FAIL coalesce_latency: INTR at cycle %0d expected %0d", found, exp_c); end
        if4.INTR_DONE = 1'b1; if4.STATUS_RD = 1'b1;
        exp_s = q_snap.pop_front();
        checks++; if (if4.STATUS_DATA !== exp_s) begin errors++; $display("FAIL coalesce_snapshot: got %h expected %h", if4.STATUS_DATA, exp_s); end
        tick(); if4.INTR_DONE = 1'b0; if4.STATUS_RD = 1'b0;
        checks++; if (if4.BUSY !== 1'b0 || if4.STATUS_DATA !== 32'h0) begin errors++; $display("FAIL coalesce_exit: busy %b data %h expected 0 0", if4.BUSY, if4.STATUS_DATA); end
    endtask

    task automatic test_event_in_req();
        int t, e, found, exp_c;
        logic [31:0] exp_s;
        if0.CONFIG_INTERRUPT_MSIENABLE = 1'b1;
        t = cyc;
        if0.CHNL_EVENT = 24'(1) << tx_bit(0);
        q_cyc.push_back(t + 2); q_snap.push_back(32'h0000_0002);
        tick(); if0.CHNL_EVENT = '0;
        wait_intr(1'b0, found);
        exp_c = q_cyc.pop_front();
        checks++; if (found !== exp_c) begin errors++; $display("FAIL req_first_latency: INTR at cycle %0d expected %0d", found, exp_c); end
        if0.CHNL_EVENT = 24'(1) << rx_bit(1);
        q_snap.push_back(32'h0000_0004);
        tick(); if0.CHNL_EVENT = '0; if0.STATUS_RD = 1'b1;
        exp_s = q_snap.pop_front();
        checks++; if (if0.STATUS_DATA !== exp_s) begin errors++; $display("FAIL req_first_snapshot: got %h expected %h", if0.STATUS_DATA, exp_s); end
        tick(); if0.STATUS_RD = 1'b0; if0.INTR_DONE = 1'b1;
        e = cyc;
        q_cyc.push_back(e + 2);
        tick(); if0.INTR_DONE = 1'b0;
        checks++; if (if0.INTR !== 1'b0) begin errors++; $display("FAIL req_early_intr: got %b expected 0", if0.INTR); end
        wait_intr(1'b0, found);
        exp_c = q_cyc.pop_front();
        checks++; if (found !== exp_c) begin errors++; $display("FAIL req_second_latency: INTR at cycle %0d expected %0d", found, exp_c); end
        tick(); if0.INTR_DONE = 1'b1; if0.STATUS_RD = 1'b1;
        exp_s = q_snap.pop_front();
        checks++; if (if0.STATUS_DATA !== exp_s) begin errors++; $display("FAIL req_second_snapshot: got %h expected %h", if0.STATUS_DATA, exp_s); end
        tick(); if0.INTR_DONE = 1'b0; if0.STATUS_RD = 1'b0;
        checks++; if (if0.BUSY !== 1'b0) begin errors++; $display("FAIL req_second_exit: busy %b expected 0", if0.BUSY); end
    endtask

    task automatic test_same_cycle();
        int t, found, exp_c;
        logic [31:0] exp_s;
        if0.CONFIG_INTERRUPT_MSIENABLE = 1'b1;
        t = cyc;
        if0.CHNL_EVENT = 24'(1) << tx_bit(2);
        q_cyc.push_back(t + 2); q_snap.push_back(32'h0000_0020);
        tick(); if0.CHNL_EVENT = '0;
        wait_intr(1'b0, found);
        exp_c = q_cyc.pop_front();
        checks++; if (found !== exp_c) begin errors++; $display("FAIL same_latency: INTR at cycle %0d expected %0d", found, exp_c); end
        tick(); if0.INTR_DONE = 1'b1; if0.STATUS_RD = 1'b1;
        exp_s = q_snap.pop_front();
        checks++; if (if0.STATUS_DATA !== exp_s) begin errors++; $display("FAIL same_snapshot: got %h expected %h", if0.STATUS_DATA, exp_s); end
        tick(); if0.INTR_DONE = 1'b0; if0.CONFIG_INTERRUPT_MSIENABLE = 1'b0;
        checks++; if (if0.BUSY !== 1'b0) begin errors++; $display("FAIL same_exit: busy %b expected 0", if0.BUSY); end
        checks++; if (if0.STATUS_DATA !== 32'h0) begin errors++; $display("FAIL same_dup_data: got %h expected 0", if0.STATUS_DATA); end
        tick(); if0.STATUS_RD = 1'b0;
        checks++; if (if0.INTR_LEGACY_CLR !== 1'b0) begin errors++; $display("FAIL same_dup_clr: got %b expected 0", if0.INTR_LEGACY_CLR); end
        if0.CONFIG_INTERRUPT_MSIENABLE = 1'b1;
        tick();
    endtask

    task automatic test_reset_in_wait();
        int t, found, exp_c, npulse;
        logic [31:0] exp_s;
        if0.CONFIG_INTERRUPT_MSIENABLE = 1'b1;
        t = cyc;
        if0.CHNL_EVENT = 24'(1) << tx_bit(3);
        q_cyc.push_back(t + 2); q_snap.push_back(32'h0000_0080);
        tick(); if0.CHNL_EVENT = '0;
        wait_intr(1'b0, found);
        exp_c = q_cyc.pop_front();
        checks++; if (found !== exp_c) begin errors++; $display("FAIL rstw_latency: INTR at cycle %0d expected %0d", found, exp_c); end
        tick();
        exp_s = q_snap.pop_front();
        checks++; if (if0.STATUS_DATA !== exp_s) begin errors++; $display("FAIL rstw_snapshot: got %h expected %h", if0.STATUS_DATA, exp_s); end
        if0.CHNL_EVENT = 24'(1) << tx_bit(3);
        tick(); if0.CHNL_EVENT = '0; rst = 1'b1;
        tick(); rst = 1'b0;
        checks++; if (if0.INTR !== 1'b0 || if0.INTR_LEGACY_CLR !== 1'b0) begin errors++; $display("FAIL rstw_pulses: intr %b clr %b expected 0 0", if0.INTR, if0.INTR_LEGACY_CLR); end
        checks++; if (if0.BUSY !== 1'b0) begin errors++; $display("FAIL rstw_busy: got %b expected 0", if0.BUSY); end
        checks++; if (if0.STATUS_DATA !== 32'h0) begin errors++; $display("FAIL rstw_data: got %h expected 0", if0.STATUS_DATA); end
        npulse = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (if0.INTR === 1'b1 || if0.BUSY === 1'b1) npulse++;
        end
        checks++; if (npulse !== 0) begin errors++; $display("FAIL rstw_quiet: got %0d active cycles expected 0", npulse); end
    endtask

    initial begin
        test_reset();
        test_msi_basic();
        test_legacy();
        test_coalesce();
        test_event_in_req();
        test_same_cycle();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule : tb_interrupt_status_collector
`default_nettype wire
